// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ENTRY_W = 2 * XLEN;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    F_RUN  = 1'b0,
    F_DROP = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with synchronous flush; the head is read
// straight from storage registers so outputs carry no combinational input path.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [ENTRY_W-1:0]      push_data,
  input  logic                    pop,
  output logic                    head_valid,
  output logic [ENTRY_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem requests, prefetch queue.
// Optional same-cycle response bypass: define INST_FETCH_BYPASS_EN.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            ack_hit;
  logic            ack_run;
  logic            push;
  logic            pop;
  logic            bypass_take;
  logic            head_valid;
  logic [ENTRY_W-1:0] head_bits;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;

  assign target     = jump_target & ~32'h3;
  assign pc_plus4   = fetch_pc + 32'd4;
  assign ack_hit    = imem_ack && imem_req;
  assign ack_run    = ack_hit && (state == F_RUN) && !jump_flag;
  assign push_entry = '{pc: fetch_pc, inst: imem_rdata};
  assign head_entry = fetch_entry_t'(head_bits);

  // Decoder handshake: an entry transfers on any rising edge where inst_valid
  // and inst_ready are both high; inst_valid never waits on inst_ready.
`ifdef INST_FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit  = ack_run && !head_valid;
  assign bypass_take = bypass_hit && inst_ready;
  assign inst_valid  = head_valid || bypass_hit;
  assign inst        = bypass_hit ? imem_rdata : head_entry.inst;
  assign inst_pc     = bypass_hit ? fetch_pc : head_entry.pc;
`else
  assign bypass_take = 1'b0;
  assign inst_valid  = head_valid;
  assign inst        = head_entry.inst;
  assign inst_pc     = head_entry.pc;
`endif

  assign push = ack_run && !bypass_take;
  assign pop  = head_valid && inst_ready;

  always_comb begin
    count_next = count;
    if (jump_flag) count_next = '0;
    else           count_next = count + CW'(push) - CW'(pop);
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (jump_flag),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_bits),
    .count      (count)
  );

  // While a request is pending (req high, no ack) req and addr are frozen;
  // a jump that abandons it parks in F_DROP until the stale ack is swallowed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= F_RUN;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        F_RUN: begin
          if (jump_flag) begin
            fetch_pc <= target;
            if (imem_req && !imem_ack) begin
              state <= F_DROP;
            end else begin
              imem_req  <= 1'b1;
              imem_addr <= target;
            end
          end else if (!(imem_req && !imem_ack)) begin
            if (ack_hit) fetch_pc <= pc_plus4;
            imem_req  <= (count_next < DEPTH_C);
            imem_addr <= ack_hit ? pc_plus4 : fetch_pc;
          end
        end
        F_DROP: begin
          if (jump_flag) fetch_pc <= target;
          if (imem_ack) begin
            state     <= F_RUN;
            imem_req  <= 1'b1;
            imem_addr <= jump_flag ? target : fetch_pc;
          end
        end
        default: state <= F_RUN;
      endcase
    end
  end
endmodule
